// File: rtl/tnet_pkg.sv
// Shared types and constants for the Aurora channel-B TX arbiter.
package tnet_pkg;
  localparam int TNET_DW = 128;

  typedef enum logic {GNT_FWD, GNT_LOC} grant_t;

  typedef enum logic [1:0] {LOC_IDLE, LOC_PEND, LOC_ACK} loc_st_t;
endpackage

// File: rtl/aurora_tx_arbiter_if.sv
// Channel-B TX AXI-Stream bundle. A word transfers on the rising edge where tvalid & tready;
// once tvalid is high, tdata and tvalid stay stable until that transfer.
interface aurora_tx_arbiter_if;
  import tnet_pkg::*;

  logic [TNET_DW-1:0] m_axi_tx_tdata_B;
  logic               m_axi_tx_tvalid_B;
  logic               m_axi_tx_tready_B;

  modport master (output m_axi_tx_tdata_B, output m_axi_tx_tvalid_B, input m_axi_tx_tready_B);
  modport slave  (input m_axi_tx_tdata_B, input m_axi_tx_tvalid_B, output m_axi_tx_tready_B);
endinterface

// File: rtl/tnet_sfifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is taken when a read pops the same cycle.
module tnet_sfifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                     user_clock,
  input  logic                     user_aresetn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_dt,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_dt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign full  = (cnt == FULL_LVL);
  assign empty = (cnt == '0);
  assign level = cnt;
  assign rd_dt = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge user_clock) begin
    if (do_wr) mem[wr_ptr] <= wr_dt;
  end

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/aurora_tx_arbiter.sv
// Round-robin arbiter sharing the channel-B TX stream between buffered forwarded words
// and a four-phase local requester, with traffic/drop status counters.
module aurora_tx_arbiter
  import tnet_pkg::*;
#(
  parameter int FWD_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         user_clock,
  input  logic                         user_aresetn,
  input  logic                         channel_up_B,
  input  logic                         fwd_valid_i,
  input  logic [TNET_DW-1:0]           fwd_data_i,
  input  logic                         loc_req_i,
  input  logic [TNET_DW-1:0]           loc_data_i,
  output logic                         loc_ack_o,
  aurora_tx_arbiter_if.master          tx,
  output logic [CNT_W-1:0]             fwd_cnt_o,
  output logic [CNT_W-1:0]             loc_cnt_o,
  output logic [CNT_W-1:0]             drop_cnt_o,
  output logic [$clog2(FWD_DEPTH):0]   fifo_lvl_o,
  output loc_st_t                      loc_state_o
);
  logic [TNET_DW-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_wr;
  logic               fifo_pop;
  logic               drop;

  logic [TNET_DW-1:0] out_data;
  logic               out_valid;
  grant_t             out_src;
  grant_t             last_grant;
  grant_t             grant;
  logic               hs;
  logic               load_en;
  logic               load_fire;
  logic               fwd_cand;
  logic               loc_cand;

  loc_st_t            loc_state;
  loc_st_t            loc_state_nxt;

  // Forwarded words cannot be back-pressured: a full FIFO with no pop loses the word.
  assign fifo_wr = fwd_valid_i & channel_up_B;
  assign drop    = fifo_wr & fifo_full & ~fifo_pop;

  tnet_sfifo #(.DW(TNET_DW), .DEPTH(FWD_DEPTH)) u_fifo (
    .user_clock   (user_clock),
    .user_aresetn (user_aresetn),
    .flush        (~channel_up_B),
    .wr_en        (fifo_wr),
    .wr_dt        (fwd_data_i),
    .rd_en        (fifo_pop),
    .rd_dt        (fifo_rd),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .level        (fifo_lvl_o)
  );

  assign hs        = out_valid & tx.m_axi_tx_tready_B;
  assign load_en   = (~out_valid | hs) & channel_up_B;
  assign fwd_cand  = ~fifo_empty;
  assign loc_cand  = (loc_state == LOC_PEND) & loc_req_i;
  assign load_fire = load_en & (fwd_cand | loc_cand);
  assign fifo_pop  = load_fire & (grant == GNT_FWD);

  always_comb begin
    grant = GNT_FWD;
    if (fwd_cand && loc_cand) grant = (last_grant == GNT_LOC) ? GNT_FWD : GNT_LOC;
    else if (loc_cand)        grant = GNT_LOC;
  end

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_src    <= GNT_FWD;
      last_grant <= GNT_LOC;
    end else if (load_fire) begin
      out_data   <= (grant == GNT_FWD) ? fifo_rd : loc_data_i;
      out_valid  <= 1'b1;
      out_src    <= grant;
      last_grant <= grant;
    end else if (hs) begin
      out_valid  <= 1'b0;
    end
  end

  assign tx.m_axi_tx_tdata_B  = out_data;
  assign tx.m_axi_tx_tvalid_B = out_valid;

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      fwd_cnt_o  <= '0;
      loc_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (hs && out_src == GNT_FWD) fwd_cnt_o <= fwd_cnt_o + 1'b1;
      if (hs && out_src == GNT_LOC) loc_cnt_o <= loc_cnt_o + 1'b1;
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      loc_state <= LOC_IDLE;
      loc_ack_o <= 1'b0;
    end else begin
      loc_state <= loc_state_nxt;
      // Ack trails the ACK state by one cycle and falls together with the request.
      loc_ack_o <= (loc_state == LOC_ACK) & loc_req_i;
    end
  end

  always_comb begin
    loc_state_nxt = loc_state;
    case (loc_state)
      LOC_IDLE: if (loc_req_i) loc_state_nxt = LOC_PEND;
      LOC_PEND: begin
        if (!loc_req_i)                          loc_state_nxt = LOC_IDLE;
        else if (load_fire && grant == GNT_LOC)  loc_state_nxt = LOC_ACK;
      end
      LOC_ACK:  if (!loc_req_i) loc_state_nxt = LOC_IDLE;
      default:  loc_state_nxt = LOC_IDLE;
    endcase
  end

  assign loc_state_o = loc_state;
endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: latency, backpressure, round-robin order, overflow,
// channel-down flush and asynchronous reset, each scenario with hand-computed expectations.
module tb_aurora_tx_arbiter;
  import tnet_pkg::*;

  localparam int W = 128;

  logic         user_clock = 1'b0;
  logic         user_aresetn = 1'b0;
  logic         channel_up_B = 1'b1;
  logic         fwd_valid_i = 1'b0;
  logic [W-1:0] fwd_data_i = '0;
  logic         loc_req_i = 1'b0;
  logic [W-1:0] loc_data_i = '0;
  logic         loc_ack_o;
  logic [15:0]  fwd_cnt_o;
  logic [15:0]  loc_cnt_o;
  logic [15:0]  drop_cnt_o;
  logic [2:0]   fifo_lvl_o;
  loc_st_t      loc_state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int n_tests = 0;
  int n_fail  = 0;

  aurora_tx_arbiter_if tx();

  aurora_tx_arbiter #(.FWD_DEPTH(4), .CNT_W(16)) dut (
    .user_clock   (user_clock),
    .user_aresetn (user_aresetn),
    .channel_up_B (channel_up_B),
    .fwd_valid_i  (fwd_valid_i),
    .fwd_data_i   (fwd_data_i),
    .loc_req_i    (loc_req_i),
    .loc_data_i   (loc_data_i),
    .loc_ack_o    (loc_ack_o),
    .tx           (tx),
    .fwd_cnt_o    (fwd_cnt_o),
    .loc_cnt_o    (loc_cnt_o),
    .drop_cnt_o   (drop_cnt_o),
    .fifo_lvl_o   (fifo_lvl_o),
    .loc_state_o  (loc_state_o)
  );

  // Clock / reset
  always #5 user_clock = ~user_clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge user_clock);
    #1;
  endtask

  task automatic test_reset();
    tx.m_axi_tx_tready_B = 1'b0;
    user_aresetn = 1'b0;
    step();
    step();
    if ({tx.m_axi_tx_tvalid_B, loc_ack_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_ack: got %b expected 00", {tx.m_axi_tx_tvalid_B, loc_ack_o});
    end
    n_tests++;
    if ({fwd_cnt_o, loc_cnt_o, drop_cnt_o} !== 48'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected 0", {fwd_cnt_o, loc_cnt_o, drop_cnt_o});
    end
    n_tests++;
    if (fifo_lvl_o !== 3'd0 || loc_state_o !== LOC_IDLE) begin
      n_fail++; $display("FAIL reset_lvl_state: got lvl %0d state %0d expected 0 0", fifo_lvl_o, loc_state_o);
    end
    n_tests++;
    user_aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_fwd();
    tx.m_axi_tx_tready_B = 1'b1;
    fwd_valid_i = 1'b1;
    fwd_data_i  = {16{8'hA5}};
    step();
    fwd_valid_i = 1'b0;
    if (tx.m_axi_tx_tvalid_B !== 1'b0) begin
      n_fail++; $display("FAIL fwd_tvalid_n1: got %b expected 0", tx.m_axi_tx_tvalid_B);
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL fwd_word_n2: got v=%b d=%h expected v=1 d=%h", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, {16{8'hA5}});
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || fwd_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL fwd_done_n3: got v=%b cnt=%0d expected v=0 cnt=1", tx.m_axi_tx_tvalid_B, fwd_cnt_o);
    end
    n_tests++;
  endtask

  task automatic test_local_backpressure();
    tx.m_axi_tx_tready_B = 1'b0;
    loc_req_i  = 1'b1;
    loc_data_i = 128'h1234;
    step();
    if (loc_state_o !== LOC_PEND || tx.m_axi_tx_tvalid_B !== 1'b0) begin
      n_fail++; $display("FAIL loc_pend_n1: got state %0d v=%b expected %0d v=0", loc_state_o, tx.m_axi_tx_tvalid_B, LOC_PEND);
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'h1234 || loc_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL loc_word_n2: got v=%b d=%h ack=%b expected v=1 d=1234 ack=0", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, loc_ack_o);
    end
    n_tests++;
    step();
    if (loc_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL loc_ack_n3: got %b expected 1", loc_ack_o);
    end
    n_tests++;
    step();
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'h1234 || loc_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL loc_hold: got v=%b d=%h cnt=%0d expected v=1 d=1234 cnt=0", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, loc_cnt_o);
    end
    n_tests++;
    tx.m_axi_tx_tready_B = 1'b1;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || loc_cnt_o !== 16'd1 || loc_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL loc_sent: got v=%b cnt=%0d ack=%b expected v=0 cnt=1 ack=1", tx.m_axi_tx_tvalid_B, loc_cnt_o, loc_ack_o);
    end
    n_tests++;
    loc_req_i = 1'b0;
    step();
    if (loc_ack_o !== 1'b0 || loc_state_o !== LOC_IDLE) begin
      n_fail++; $display("FAIL loc_release: got ack=%b state %0d expected ack=0 state 0", loc_ack_o, loc_state_o);
    end
    n_tests++;
  endtask

  task automatic test_round_robin();
    tx.m_axi_tx_tready_B = 1'b1;
    exp_q = {128'hF0, 128'hC1, 128'hF1, 128'hF2};
    fwd_valid_i = 1'b1;
    fwd_data_i  = 128'hF0;
    loc_req_i   = 1'b1;
    loc_data_i  = 128'hC1;
    step();
    fwd_data_i  = 128'hF1;
    step();
    fwd_data_i  = 128'hF2;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) fwd_valid_i = 1'b0;
      exp_w = exp_q.pop_front();
      if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== exp_w) begin
        n_fail++; $display("FAIL rr_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, exp_w);
      end
      n_tests++;
      step();
    end
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || fwd_cnt_o !== 16'd4 || loc_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL rr_counts: got v=%b fwd=%0d loc=%0d expected v=0 fwd=4 loc=2", tx.m_axi_tx_tvalid_B, fwd_cnt_o, loc_cnt_o);
    end
    n_tests++;
    loc_req_i = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    tx.m_axi_tx_tready_B = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fwd_valid_i = 1'b1;
      fwd_data_i  = 128'hD0 + W'(i);
      step();
    end
    fwd_valid_i = 1'b0;
    if (fifo_lvl_o !== 3'd4 || drop_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL ovf_lvl_drop: got lvl=%0d drop=%0d expected lvl=4 drop=1", fifo_lvl_o, drop_cnt_o);
    end
    n_tests++;
    for (int i = 0; i < 5; i++) exp_q.push_back(128'hD0 + W'(i));
    tx.m_axi_tx_tready_B = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_w = exp_q.pop_front();
      if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== exp_w) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, exp_w);
      end
      n_tests++;
      step();
    end
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || fwd_cnt_o !== 16'd9 || drop_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL ovf_end: got v=%b fwd=%0d drop=%0d expected v=0 fwd=9 drop=1", tx.m_axi_tx_tvalid_B, fwd_cnt_o, drop_cnt_o);
    end
    n_tests++;
  endtask

  task automatic test_channel_down();
    tx.m_axi_tx_tready_B = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fwd_valid_i = 1'b1;
      fwd_data_i  = 128'hE0 + W'(i);
      step();
    end
    if (fifo_lvl_o !== 3'd3 || tx.m_axi_tx_tdata_B !== 128'hE0) begin
      n_fail++; $display("FAIL down_setup: got lvl=%0d d=%h expected lvl=3 d=e0", fifo_lvl_o, tx.m_axi_tx_tdata_B);
    end
    n_tests++;
    channel_up_B = 1'b0;
    fwd_data_i   = 128'hBAD;
    loc_req_i    = 1'b1;
    loc_data_i   = 128'hCC;
    step();
    fwd_valid_i = 1'b0;
    if (fifo_lvl_o !== 3'd0 || tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'hE0 || drop_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL down_flush: got lvl=%0d v=%b d=%h drop=%0d expected lvl=0 v=1 d=e0 drop=1", fifo_lvl_o, tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B, drop_cnt_o);
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || loc_state_o !== LOC_PEND) begin
      n_fail++; $display("FAIL down_hold: got v=%b state %0d expected v=1 state %0d", tx.m_axi_tx_tvalid_B, loc_state_o, LOC_PEND);
    end
    n_tests++;
    tx.m_axi_tx_tready_B = 1'b1;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || fwd_cnt_o !== 16'd10) begin
      n_fail++; $display("FAIL down_sent: got v=%b fwd=%0d expected v=0 fwd=10", tx.m_axi_tx_tvalid_B, fwd_cnt_o);
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b0 || loc_state_o !== LOC_PEND) begin
      n_fail++; $display("FAIL down_no_load: got v=%b state %0d expected v=0 state %0d", tx.m_axi_tx_tvalid_B, loc_state_o, LOC_PEND);
    end
    n_tests++;
    channel_up_B = 1'b1;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'hCC) begin
      n_fail++; $display("FAIL up_local: got v=%b d=%h expected v=1 d=cc", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B);
    end
    n_tests++;
    step();
    if (loc_cnt_o !== 16'd3 || loc_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL up_local_done: got loc=%0d ack=%b expected loc=3 ack=1", loc_cnt_o, loc_ack_o);
    end
    n_tests++;
  endtask

  task automatic test_async_reset();
    tx.m_axi_tx_tready_B = 1'b0;
    fwd_valid_i = 1'b1;
    fwd_data_i  = 128'h77;
    step();
    fwd_valid_i = 1'b0;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || loc_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_setup: got v=%b ack=%b expected v=1 ack=1", tx.m_axi_tx_tvalid_B, loc_ack_o);
    end
    n_tests++;
    #2;
    user_aresetn = 1'b0;
    loc_req_i    = 1'b0;
    #1;
    if ({tx.m_axi_tx_tvalid_B, loc_ack_o} !== 2'b00 || tx.m_axi_tx_tdata_B !== '0) begin
      n_fail++; $display("FAIL rst_async_out: got v=%b ack=%b d=%h expected all 0", tx.m_axi_tx_tvalid_B, loc_ack_o, tx.m_axi_tx_tdata_B);
    end
    n_tests++;
    if ({fwd_cnt_o, loc_cnt_o, drop_cnt_o} !== 48'h0 || fifo_lvl_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_async_cnt: got %h lvl=%0d expected 0 lvl=0", {fwd_cnt_o, loc_cnt_o, drop_cnt_o}, fifo_lvl_o);
    end
    n_tests++;
    step();
    user_aresetn = 1'b1;
    tx.m_axi_tx_tready_B = 1'b1;
    step();
    fwd_valid_i = 1'b1;
    fwd_data_i  = 128'hAF;
    loc_req_i   = 1'b1;
    loc_data_i  = 128'hAC;
    step();
    fwd_valid_i = 1'b0;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'hAF) begin
      n_fail++; $display("FAIL tie_first_fwd: got v=%b d=%h expected v=1 d=af", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B);
    end
    n_tests++;
    step();
    if (tx.m_axi_tx_tvalid_B !== 1'b1 || tx.m_axi_tx_tdata_B !== 128'hAC) begin
      n_fail++; $display("FAIL tie_then_loc: got v=%b d=%h expected v=1 d=ac", tx.m_axi_tx_tvalid_B, tx.m_axi_tx_tdata_B);
    end
    n_tests++;
    step();
    if (fwd_cnt_o !== 16'd1 || loc_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL tie_counts: got fwd=%0d loc=%0d expected 1 1", fwd_cnt_o, loc_cnt_o);
    end
    n_tests++;
    loc_req_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_local_backpressure();
    test_round_robin();
    test_overflow();
    test_channel_down();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
